xgmii_probe_rx: RTL and testbench



---
 rtl/xgmii_probe_rx_if.sv | 13 +
 rtl/xgmii_probe_rx.sv | 214 +++++++++++++++++++++
 tb/tb_xgmii_probe_rx.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xgmii_probe_rx_if.sv
// xgmii_probe_rx_if
//   64-bit XGMII receive bus, one byte lane per control bit.
//   master : the PHY/PCS side that drives the stream
//   slave  : the probe receiver that parses the stream
//   xgmii_rxd[63:0] : lane 0 = bits[7:0] = first byte on the wire
//   xgmii_rxc[7:0]  : 1 = lane carries a control character
interface xgmii_probe_rx_if;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;

  modport master (output xgmii_rxd, output xgmii_rxc);
  modport slave  (input  xgmii_rxd, input  xgmii_rxc);
endinterface

// File: rtl/xgmii_probe_rx.sv
// xgmii_probe_rx
//   Receives probe frames from an XGMII RX stream. It checks the IPv4/UDP
//   headers and the magic code and measures one-way latency against the
//   shared global_counter. It also counts probe packets and bytes per
//   one-second window.
// Ports
//   sys_clk, sys_rst_n : 156.25 MHz clock, asynchronous active-low reset
//   sec_oneshot        : one-cycle pulse that closes the counting window
//   global_counter     : free-running cycle counter shared with the sender
//   xgmii (slave)      : xgmii_rxd / xgmii_rxc receive bus
//   rx_pps             : probe frames in the last closed window
//   rx_throughput      : probe bytes (DA..FCS) in the last closed window
//   rx_latency         : latency of the latest probe, in sys_clk cycles
//   rx_ipv4_ip         : IPv4 source address of the latest probe
// Build option
//   RX_LATENCY_MAX_EN  : when defined, rx_latency holds the maximum latency
//                        of the last closed window instead.
`ifndef MAGIC_CODE
`define MAGIC_CODE 32'hC0DE_CAFE
`endif

module xgmii_probe_rx #(
  parameter logic [31:0] MAGIC_CODE = `MAGIC_CODE,
  parameter logic [15:0] UDP_PORT   = 16'd9,
  parameter int unsigned LAT_WIDTH  = 24
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 sec_oneshot,
  input  logic [31:0]          global_counter,
  xgmii_probe_rx_if.slave      xgmii,
  output logic [31:0]          rx_pps,
  output logic [31:0]          rx_throughput,
  output logic [LAT_WIDTH-1:0] rx_latency,
  output logic [31:0]          rx_ipv4_ip
);
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;

  typedef enum logic [1:0] {IDLE, FRAME, DROP} state_t;

  state_t               state_q, state_d;
  logic [7:0]           beat_q, beat_d;      // index of the beat now on the bus
  logic                 sat_q, sat_d;        // beat counter stuck at 255, so this is beat 256
  logic [15:0]          ts_hi_q, ts_hi_d;
  logic [31:0]          srcip_q, srcip_d;
  logic [LAT_WIDTH-1:0] lat_q, lat_d;
  logic [31:0]          pkt_cnt_q, pkt_cnt_d;
  logic [31:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]          rx_pps_q, rx_pps_d;
  logic [31:0]          rx_thr_q, rx_thr_d;
  logic [31:0]          rx_ip_q, rx_ip_d;
  logic [LAT_WIDTH-1:0] rx_lat_q, rx_lat_d;
`ifdef RX_LATENCY_MAX_EN
  logic [LAT_WIDTH-1:0] lat_max_q, lat_max_d;
`endif

  logic [7:0]           lane [8];
  logic [2:0]           ctl_k;
  logic                 ctl_any, ctl_fd, fd_any, is_start, field_ok, accept;
  logic [8:0]           eff_beat;
  logic [11:0]          frame_len;
  logic [31:0]          diff;
  logic [LAT_WIDTH-1:0] lat_now;
  logic [32:0]          byte_sum;

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) lane[i] = xgmii.xgmii_rxd[8*i +: 8];
  end

  // ctl_k is the lowest control lane. fd_any is set when any control lane is a terminate.
  always_comb begin
    ctl_k  = '0;
    fd_any = 1'b0;
    for (int unsigned i = 8; i > 0; i--) if (xgmii.xgmii_rxc[i-1]) ctl_k = 3'(i - 1);
    for (int unsigned i = 0; i < 8; i++)
      if (xgmii.xgmii_rxc[i] && lane[i] == XG_TERM) fd_any = 1'b1;
  end

  assign is_start  = (xgmii.xgmii_rxc == 8'h01) && (lane[0] == XG_START);
  assign ctl_any   = |xgmii.xgmii_rxc;
  assign ctl_fd    = (lane[ctl_k] == XG_TERM);
  assign eff_beat  = sat_q ? 9'd256 : {1'b0, beat_q};
  assign frame_len = {eff_beat - 9'd1, 3'b000} + {9'd0, ctl_k};
  assign diff      = global_counter - {ts_hi_q, lane[0], lane[1]};
  assign lat_now   = (|diff[31:LAT_WIDTH]) ? '1 : diff[LAT_WIDTH-1:0];

  always_comb begin
    field_ok = 1'b1;
    if (!sat_q) begin
      case (beat_q)
        8'd2: field_ok = ({lane[4], lane[5]} == 16'h0800) && (lane[6] == 8'h45);
        8'd3: field_ok = (lane[7] == 8'h11);
        8'd5: field_ok = ({lane[4], lane[5]} == UDP_PORT);
        8'd6: field_ok = ({lane[2], lane[3], lane[4], lane[5]} == MAGIC_CODE);
        default: field_ok = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    sat_d      = sat_q;
    ts_hi_d    = ts_hi_q;
    srcip_d    = srcip_q;
    lat_d      = lat_q;
    pkt_cnt_d  = pkt_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rx_pps_d   = rx_pps_q;
    rx_thr_d   = rx_thr_q;
    rx_ip_d    = rx_ip_q;
    rx_lat_d   = rx_lat_q;
`ifdef RX_LATENCY_MAX_EN
    lat_max_d  = lat_max_q;
`endif
    accept     = 1'b0;
    byte_sum   = '0;

    if (is_start) begin
      // A start always wins, even mid-frame. Counting resumes at beat 1 on the next cycle.
      state_d = FRAME;
      beat_d  = 8'd1;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        FRAME: begin
          if (ctl_any) begin
            state_d = ctl_fd ? IDLE : DROP;
            accept  = ctl_fd && (eff_beat >= 9'd9) &&
                      (frame_len >= 12'd64) && (frame_len <= 12'd2040);
          end else if (!field_ok || sat_q) begin
            state_d = DROP;
          end else begin
            if (beat_q == 8'd4) srcip_d = {lane[2], lane[3], lane[4], lane[5]};
            if (beat_q == 8'd6) ts_hi_d = {lane[6], lane[7]};
            if (beat_q == 8'd7) lat_d   = lat_now;
            if (beat_q == 8'hFF) sat_d = 1'b1;
            else                 beat_d = beat_q + 8'd1;
          end
        end
        DROP:    if (fd_any) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (accept) begin
      rx_ip_d = srcip_q;
`ifndef RX_LATENCY_MAX_EN
      rx_lat_d = lat_q;
`endif
    end

    // On a window boundary the old counts are published, and a coinciding accept starts the new window.
    if (sec_oneshot) begin
      rx_pps_d   = pkt_cnt_q;
      rx_thr_d   = byte_cnt_q;
      pkt_cnt_d  = accept ? 32'd1 : '0;
      byte_cnt_d = accept ? {20'd0, frame_len} : '0;
`ifdef RX_LATENCY_MAX_EN
      rx_lat_d   = lat_max_q;
      lat_max_d  = accept ? lat_q : '0;
`endif
    end else if (accept) begin
      pkt_cnt_d  = (pkt_cnt_q == '1) ? '1 : pkt_cnt_q + 32'd1;
      byte_sum   = {1'b0, byte_cnt_q} + {21'd0, frame_len};
      byte_cnt_d = byte_sum[32] ? '1 : byte_sum[31:0];
`ifdef RX_LATENCY_MAX_EN
      if (lat_q > lat_max_q) lat_max_d = lat_q;
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      sat_q      <= 1'b0;
      ts_hi_q    <= '0;
      srcip_q    <= '0;
      lat_q      <= '0;
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_pps_q   <= '0;
      rx_thr_q   <= '0;
      rx_ip_q    <= '0;
      rx_lat_q   <= '0;
`ifdef RX_LATENCY_MAX_EN
      lat_max_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      sat_q      <= sat_d;
      ts_hi_q    <= ts_hi_d;
      srcip_q    <= srcip_d;
      lat_q      <= lat_d;
      pkt_cnt_q  <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_pps_q   <= rx_pps_d;
      rx_thr_q   <= rx_thr_d;
      rx_ip_q    <= rx_ip_d;
      rx_lat_q   <= rx_lat_d;
`ifdef RX_LATENCY_MAX_EN
      lat_max_q  <= lat_max_d;
`endif
    end
  end

  assign rx_pps        = rx_pps_q;
  assign rx_throughput = rx_thr_q;
  assign rx_latency    = rx_lat_q;
  assign rx_ipv4_ip    = rx_ip_q;
endmodule

// File: tb/tb_xgmii_probe_rx.sv
`ifndef MAGIC_CODE
`define MAGIC_CODE 32'hC0DE_CAFE
`endif

module tb_xgmii_probe_rx;
  localparam logic [31:0] MAGIC = `MAGIC_CODE;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        sec_oneshot;
  logic [31:0] global_counter;
  logic [31:0] rx_pps, rx_throughput, rx_ipv4_ip;
  logic [23:0] rx_latency;

  xgmii_probe_rx_if xif ();

  xgmii_probe_rx dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .sec_oneshot   (sec_oneshot),
    .global_counter(global_counter),
    .xgmii         (xif),
    .rx_pps        (rx_pps),
    .rx_throughput (rx_throughput),
    .rx_latency    (rx_latency),
    .rx_ipv4_ip    (rx_ipv4_ip)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  // Reference model: window counters and expected published outputs
  logic [31:0] m_pkt, m_bytes, e_pps, e_thr, e_ip;
  logic [23:0] e_lat, m_max;
  logic [7:0]  fr[$];

  task automatic model_clear();
    m_pkt = '0; m_bytes = '0; e_pps = '0; e_thr = '0; e_ip = '0; e_lat = '0; m_max = '0;
  endtask

  task automatic model_publish();
    e_pps = m_pkt; e_thr = m_bytes; m_pkt = '0; m_bytes = '0;
`ifdef RX_LATENCY_MAX_EN
    e_lat = m_max; m_max = '0;
`endif
  endtask

  task automatic build_probe(input logic [31:0] ip, input logic [15:0] port,
                             input logic [31:0] magic, input logic [31:0] ts, input int len);
    fr.delete();
    for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
    fr[12] = 8'h08; fr[13] = 8'h00; fr[14] = 8'h45; fr[23] = 8'h11;
    fr[36] = port[15:8]; fr[37] = port[7:0];
    for (int i = 0; i < 4; i++) begin
      fr[26+i] = ip[31-8*i -: 8];
      fr[42+i] = magic[31-8*i -: 8];
      fr[46+i] = ts[31-8*i -: 8];
    end
  endtask

  function automatic bit model_ok(input int err_off);
    if (err_off >= 0) return 1'b0;
    if (fr.size() < 64 || fr.size() > 2040) return 1'b0;
    return ({fr[12], fr[13]} == 16'h0800) && (fr[14] == 8'h45) && (fr[23] == 8'h11) &&
           ({fr[36], fr[37]} == 16'd9) && ({fr[42], fr[43], fr[44], fr[45]} == MAGIC);
  endfunction

  // Sends preamble, frame, terminate and fill, then one idle beat.
  // global_counter equals gc7 on beat 7.
  task automatic send(input int err_off, input logic [31:0] gc7, input bit coinc, input int rst_beat);
    logic [7:0] sb[$];
    bit         sc[$];
    logic [63:0] d;
    logic [7:0]  c;
    int nb;
    sb.push_back(8'hFB); sc.push_back(1'b1);
    for (int i = 0; i < 6; i++) begin sb.push_back(8'h55); sc.push_back(1'b0); end
    sb.push_back(8'hD5); sc.push_back(1'b0);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == err_off) begin sb.push_back(8'hFE); sc.push_back(1'b1); end
      else begin sb.push_back(fr[i]); sc.push_back(1'b0); end
    end
    sb.push_back(8'hFD); sc.push_back(1'b1);
    while (sb.size() % 8 != 0) begin sb.push_back(8'h07); sc.push_back(1'b1); end
    nb = sb.size() / 8;
    for (int b = 0; b < nb; b++) begin
      @(negedge sys_clk);
      for (int l = 0; l < 8; l++) begin d[8*l +: 8] = sb[8*b+l]; c[l] = sc[8*b+l]; end
      xif.xgmii_rxd  = d;
      xif.xgmii_rxc  = c;
      global_counter = gc7 - 32'd7 + 32'(b);
      sec_oneshot    = coinc && (b == nb - 1);
      if (b == rst_beat)     sys_rst_n = 1'b0;
      if (b == rst_beat + 2) sys_rst_n = 1'b1;
    end
    @(negedge sys_clk);
    xif.xgmii_rxd = {8{8'h07}}; xif.xgmii_rxc = 8'hFF;
    sec_oneshot = 1'b0; global_counter = global_counter + 32'd1;
  endtask

  // Sends the frame in fr and updates the model from the frame's own bytes.
  task automatic run_frame(input int err_off, input logic [31:0] gc7, input bit coinc, input int rst_beat);
    bit acc;
    logic [31:0] d, ip;
    logic [23:0] lat;
    logic [32:0] s;
    acc = model_ok(err_off);
    d   = gc7 - {fr[46], fr[47], fr[48], fr[49]};
    lat = (d > 32'h00FF_FFFF) ? 24'hFF_FFFF : d[23:0];
    ip  = {fr[26], fr[27], fr[28], fr[29]};
    send(err_off, gc7, coinc, rst_beat);
    if (rst_beat >= 0) begin model_clear(); return; end
    if (coinc) model_publish();
    if (acc) begin
      m_pkt   = (m_pkt == '1) ? m_pkt : m_pkt + 32'd1;
      s       = {1'b0, m_bytes} + 33'(fr.size());
      m_bytes = s[32] ? '1 : s[31:0];
      e_ip    = ip;
`ifdef RX_LATENCY_MAX_EN
      if (lat > m_max) m_max = lat;
`else
      e_lat = lat;
`endif
    end
  endtask

  task automatic pulse_sec();
    @(negedge sys_clk); sec_oneshot = 1'b1;
    @(negedge sys_clk); sec_oneshot = 1'b0;
    model_publish();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    tests += 4;
    if (rx_pps !== 32'd0)        begin fails++; $display("FAIL reset_pps got %h exp 0", rx_pps); end
    if (rx_throughput !== 32'd0) begin fails++; $display("FAIL reset_thr got %h exp 0", rx_throughput); end
    if (rx_latency !== 24'd0)    begin fails++; $display("FAIL reset_lat got %h exp 0", rx_latency); end
    if (rx_ipv4_ip !== 32'd0)    begin fails++; $display("FAIL reset_ip got %h exp 0", rx_ipv4_ip); end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_latency();
    build_probe(32'h0A00_1469, 16'd9, MAGIC, 32'h0000_1000, 64);
    run_frame(-1, 32'h0000_1064, 1'b0, -1);
    tests += 2;
    if (rx_ipv4_ip !== 32'h0A00_1469) begin fails++; $display("FAIL lat_ip got %h exp 0a001469", rx_ipv4_ip); end
    if (rx_latency !== e_lat)         begin fails++; $display("FAIL lat_val got %h exp %h", rx_latency, e_lat); end
  endtask

  task automatic test_back_to_back();
    pulse_sec();
    for (int i = 0; i < 10; i++) begin
      build_probe($urandom, 16'd9, MAGIC, $urandom, 64);
      run_frame(-1, {fr[46], fr[47], fr[48], fr[49]} + $urandom_range(0, 5000), 1'b0, -1);
    end
    pulse_sec();
    tests += 4;
    if (rx_pps !== 32'd10)        begin fails++; $display("FAIL b2b_pps got %0d exp 10", rx_pps); end
    if (rx_throughput !== 32'd640) begin fails++; $display("FAIL b2b_thr got %0d exp 640", rx_throughput); end
    if (rx_ipv4_ip !== e_ip)      begin fails++; $display("FAIL b2b_ip got %h exp %h", rx_ipv4_ip, e_ip); end
    if (rx_latency !== e_lat)     begin fails++; $display("FAIL b2b_lat got %h exp %h", rx_latency, e_lat); end
    pulse_sec();
    tests += 2;
    if (rx_pps !== 32'd0)        begin fails++; $display("FAIL empty_pps got %0d exp 0", rx_pps); end
    if (rx_throughput !== 32'd0) begin fails++; $display("FAIL empty_thr got %0d exp 0", rx_throughput); end
  endtask

  task automatic test_drops();
    logic [31:0] ip0;
    logic [23:0] lat0;
    ip0 = e_ip; lat0 = e_lat;
    build_probe($urandom, 16'd9, MAGIC ^ 32'h0000_0100, 32'd0, 64); run_frame(-1, 32'd5, 1'b0, -1);
    build_probe($urandom, 16'd10, MAGIC, 32'd0, 64);                run_frame(-1, 32'd5, 1'b0, -1);
    build_probe($urandom, 16'd9, MAGIC, 32'd0, 64);                 run_frame(33, 32'd5, 1'b0, -1);
    build_probe($urandom, 16'd9, MAGIC, 32'd0, 63);                 run_frame(-1, 32'd5, 1'b0, -1);
    pulse_sec();
    tests += 4;
    if (rx_pps !== 32'd0)        begin fails++; $display("FAIL drop_pps got %0d exp 0", rx_pps); end
    if (rx_throughput !== 32'd0) begin fails++; $display("FAIL drop_thr got %0d exp 0", rx_throughput); end
    if (rx_ipv4_ip !== ip0)      begin fails++; $display("FAIL drop_ip got %h exp %h", rx_ipv4_ip, ip0); end
    if (rx_latency !== lat0)     begin fails++; $display("FAIL drop_lat got %h exp %h", rx_latency, lat0); end
  endtask

  task automatic test_wrap_sat();
    build_probe(32'h0102_0304, 16'd9, MAGIC, 32'hFFFF_FFF0, 64);
    run_frame(-1, 32'h0000_0010, 1'b0, -1);
    tests++;
    if (rx_latency !== e_lat) begin fails++; $display("FAIL wrap_lat got %h exp %h", rx_latency, e_lat); end
    build_probe(32'h0506_0708, 16'd9, MAGIC, 32'h0000_0000, 64);
    run_frame(-1, 32'h0200_0000, 1'b0, -1);
    tests++;
    if (rx_latency !== e_lat) begin fails++; $display("FAIL sat_lat got %h exp %h", rx_latency, e_lat); end
  endtask

  task automatic test_coincide();
    pulse_sec();
    for (int i = 0; i < 4; i++) begin
      build_probe($urandom, 16'd9, MAGIC, 32'd100, 64);
      run_frame(-1, 32'd150, i == 3, -1);
    end
    tests += 2;
    if (rx_pps !== 32'd3)         begin fails++; $display("FAIL coin_pps got %0d exp 3", rx_pps); end
    if (rx_throughput !== 32'd192) begin fails++; $display("FAIL coin_thr got %0d exp 192", rx_throughput); end
    for (int i = 0; i < 2; i++) begin
      build_probe($urandom, 16'd9, MAGIC, 32'd100, 72);
      run_frame(-1, 32'd150, 1'b0, -1);
    end
    pulse_sec();
    tests += 2;
    if (rx_pps !== 32'd3)         begin fails++; $display("FAIL coin2_pps got %0d exp 3", rx_pps); end
    if (rx_throughput !== 32'd208) begin fails++; $display("FAIL coin2_thr got %0d exp 208", rx_throughput); end
  endtask

  task automatic test_reset_midframe();
    build_probe(32'hC0A8_0001, 16'd9, MAGIC, 32'd10, 64);
    run_frame(-1, 32'd20, 1'b0, -1);
    pulse_sec();
    build_probe(32'hC0A8_0002, 16'd9, MAGIC, 32'd10, 64);
    run_frame(-1, 32'd20, 1'b0, 4);
    tests += 4;
    if (rx_pps !== 32'd0)        begin fails++; $display("FAIL rst_pps got %h exp 0", rx_pps); end
    if (rx_throughput !== 32'd0) begin fails++; $display("FAIL rst_thr got %h exp 0", rx_throughput); end
    if (rx_latency !== 24'd0)    begin fails++; $display("FAIL rst_lat got %h exp 0", rx_latency); end
    if (rx_ipv4_ip !== 32'd0)    begin fails++; $display("FAIL rst_ip got %h exp 0", rx_ipv4_ip); end
    build_probe(32'hC0A8_0003, 16'd9, MAGIC, 32'd10, 64);
    run_frame(-1, 32'd30, 1'b0, -1);
    pulse_sec();
    tests += 3;
    if (rx_pps !== 32'd1)                 begin fails++; $display("FAIL after_rst_pps got %0d exp 1", rx_pps); end
    if (rx_ipv4_ip !== 32'hC0A8_0003)     begin fails++; $display("FAIL after_rst_ip got %h exp c0a80003", rx_ipv4_ip); end
    if (rx_latency !== e_lat)             begin fails++; $display("FAIL after_rst_lat got %h exp %h", rx_latency, e_lat); end
  endtask

  task automatic test_random();
    int len, kind, err;
    logic [31:0] ts, mask;
    pulse_sec();
    for (int n = 0; n < 40; n++) begin
      len  = $urandom_range(56, 300);
      kind = $urandom_range(0, 7);
      ts   = $urandom;
      mask = ($urandom_range(0, 1) == 1) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
      build_probe($urandom, 16'd9, MAGIC, ts, len);
      err = -1;
      case (kind)
        1: fr[13] = fr[13] ^ 8'h01;
        2: fr[14] = 8'h46;
        3: fr[23] = 8'h06;
        4: fr[37] = 8'h0A;
        5: fr[42 + $urandom_range(0, 3)] ^= 8'(1 << $urandom_range(0, 7));
        6: err = $urandom_range(0, len - 1);
        default: ;
      endcase
      run_frame(err, ts + ($urandom & mask), ($urandom_range(0, 7) == 0), -1);
      tests += 2;
      if (rx_latency !== e_lat) begin fails++; $display("FAIL rnd_lat[%0d] got %h exp %h", n, rx_latency, e_lat); end
      if (rx_ipv4_ip !== e_ip)  begin fails++; $display("FAIL rnd_ip[%0d] got %h exp %h", n, rx_ipv4_ip, e_ip); end
      if (n % 8 == 7) begin
        pulse_sec();
        tests += 2;
        if (rx_pps !== e_pps)        begin fails++; $display("FAIL rnd_pps[%0d] got %0d exp %0d", n, rx_pps, e_pps); end
        if (rx_throughput !== e_thr) begin fails++; $display("FAIL rnd_thr[%0d] got %0d exp %0d", n, rx_throughput, e_thr); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst_n = 1'b0; sec_oneshot = 1'b0; global_counter = '0;
    xif.xgmii_rxd = {8{8'h07}}; xif.xgmii_rxc = 8'hFF;
    model_clear();
    test_reset();
    test_latency();
    test_back_to_back();
    test_drops();
    test_wrap_sat();
    test_coincide();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
